hash_job_scheduler: RTL and testbench
=====================================

HASH_JOB_SCHEDULER -- requirements
Module: hash_job_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 65536, watchdog limit (used only under REQ-031).
REQ-003 SHALL have port clk  input  1  single clock; one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-005 SHALL have port req  input  NUM_REQ  per-requester job request level.
REQ-006 SHALL have port req_opcode  input  NUM_REQ x 2  00 MD5, 01 SHA-1, 10 SHA-256, 11 illegal.
REQ-007 SHALL have ports req_message_addr, req_size, req_output_addr  input  NUM_REQ x 32 each  job operands.
REQ-008 SHALL have port req_grant  output  NUM_REQ  one-cycle pulse: operands captured.
REQ-009 SHALL have port req_done  output  NUM_REQ  one-cycle pulse: job finished, digest in memory.
REQ-010 SHALL have port req_err  output  NUM_REQ  one-cycle pulse: job rejected or aborted.
REQ-011 SHALL have ports hp_start  output  1, hp_opcode  output  2, hp_message_addr, hp_size, hp_output_addr  output  32  hash-processor command.
REQ-012 SHALL have port hp_done  input  1  hash-processor done level.
REQ-013 SHALL have ports busy  output  1 and active_id  output  3  current owner.

Function
REQ-014 States SHALL be IDLE, ISSUE, SETTLE, BUSY, COMPLETE.
REQ-015 IDLE: any req high SHALL select one requester round-robin, starting from the index after the last granted (index 0 after reset).
REQ-016 On selection, operands SHALL be registered and req_grant[i] pulsed in the same clock edge; requester SHALL drop req or present a new job after grant.
REQ-017 Selected opcode 11 SHALL pulse req_grant[i] and req_err[i] together, stay in IDLE, and advance the pointer; hp_start SHALL NOT assert.
REQ-018 ISSUE: hp_start SHALL be high exactly one cycle; next state SETTLE.
REQ-019 SETTLE: one cycle, hp_done ignored (processor clears stale done on start); next state BUSY.
REQ-020 BUSY: hp_done high SHALL move to COMPLETE; otherwise remain.
REQ-021 COMPLETE: req_done[active_id] SHALL pulse one cycle; next state IDLE; new grant earliest the following cycle.
REQ-022 hp_opcode, hp_message_addr, hp_size, hp_output_addr SHALL hold registered values constant from ISSUE through COMPLETE, independent of req inputs.
REQ-023 busy SHALL be high in ISSUE, SETTLE, BUSY, COMPLETE; active_id SHALL hold the owner index in those states.
REQ-024 req deasserted before grant SHALL be treated as withdrawn; no response.
REQ-025 All requesters requesting continuously SHALL each be granted once per NUM_REQ jobs.
REQ-026 At most one bit of req_grant, req_done, req_err (excluding REQ-017 pair) SHALL be high per cycle.

Reset
REQ-027 Reset SHALL asynchronously force IDLE, pointer 0, all pulse outputs 0, hp_start 0, busy 0, active_id 0, hp_* operands 0.
REQ-028 Reset mid-job SHALL drop the job without req_done or req_err; processor recovery is the system's duty.
REQ-029 First grant after reset release SHALL be no earlier than the first clk edge with reset low.

Configuration
REQ-030 Macro HASH_SCHED_TIMEOUT_EN SHALL control the watchdog.
REQ-031 Defined: a 32-bit counter SHALL count BUSY cycles; reaching TIMEOUT_CYCLES SHALL pulse req_err[active_id], skip req_done, return to IDLE.
REQ-032 Undefined: no counter logic; BUSY waits indefinitely for hp_done.

Structure
REQ-033 Package hash_sched_pkg SHALL hold the opcode enum (MD5, SHA1, SHA256, ILLEGAL), the state enum, and digest word counts (4, 5, 8).
REQ-034 Sub-module rr_arbiter SHALL implement round-robin selection (request vector, pointer in, one-hot grant out).

Verification
REQ-035 req[0]=1, opcode 00, size 48, hp_done high 400 cycles after start -> grant[0] pulse, hp_start single pulse, done[0] exactly one cycle after hp_done sampled in BUSY.
REQ-036 req=4'b1111 held, each job 10 cycles -> grant order 0,1,2,3,0,1.
REQ-037 hp_done stale high (previous job) at ISSUE -> no early COMPLETE; done only after hp_done low then high.
REQ-038 req[2]=1 opcode 11 -> grant[2] and err[2] same cycle, hp_start never high, next grant to index 3 if requesting.
REQ-039 reset asserted in BUSY -> outputs zero immediately (no clk edge), no done pulse; new job after release runs normally.
REQ-040 HASH_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=100, hp_done held low -> err[active_id] on 100th BUSY cycle, busy low next cycle.

Source files
------------

// File: rtl/hash_sched_pkg.sv
// hash_sched_pkg: opcodes, scheduler states and digest sizes shared by the hash job scheduler.
package hash_sched_pkg;
    typedef enum logic [1:0] {OP_MD5 = 2'b00, OP_SHA1 = 2'b01, OP_SHA256 = 2'b10, OP_ILLEGAL = 2'b11} opcode_t;
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_SETTLE, S_BUSY, S_COMPLETE} state_t;
    localparam int MD5_WORDS = 4;
    localparam int SHA1_WORDS = 5;
    localparam int SHA256_WORDS = 8;
endpackage

// File: rtl/hash_job_scheduler_rr_arbiter.sv
// rr_arbiter: one-hot round-robin pick, searching upward from ptr with wrap.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [2:0]   ptr,
    output logic [N-1:0] grant
);
    always_comb begin
        grant = '0;
        for (int k = N - 1; k >= 0; k--)
            for (int i = 0; i < N; i++)
                if (req[i] && i == (int'(ptr) + k) % N) begin
                    grant = '0;
                    grant[i] = 1'b1;
                end
    end
endmodule

// File: rtl/hash_job_scheduler.sv
// hash_job_scheduler: round-robin sharing of one hash processor among NUM_REQ requesters.
// HASH_SCHED_TIMEOUT_EN adds a BUSY watchdog of TIMEOUT_CYCLES cycles.
module hash_job_scheduler
    import hash_sched_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0][1:0]  req_opcode,
    input  logic [NUM_REQ-1:0][31:0] req_message_addr,
    input  logic [NUM_REQ-1:0][31:0] req_size,
    input  logic [NUM_REQ-1:0][31:0] req_output_addr,
    output logic [NUM_REQ-1:0]       req_grant,
    output logic [NUM_REQ-1:0]       req_done,
    output logic [NUM_REQ-1:0]       req_err,
    output logic                     hp_start,
    output logic [1:0]               hp_opcode,
    output logic [31:0]              hp_message_addr,
    output logic [31:0]              hp_size,
    output logic [31:0]              hp_output_addr,
    input  logic                     hp_done,
    output logic                     busy,
    output logic [2:0]               active_id
);
    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("hash_job_scheduler: parameter out of range");
    end
    state_t state, state_nx;
    logic [2:0] ptr, sel_id;
    logic [NUM_REQ-1:0] sel, grant_q, err_q;
    logic [1:0] sel_op;
    logic [31:0] sel_ma, sel_sz, sel_oa;
    logic timeout;
    // a requester sees its grant one cycle late, so it is masked for that cycle
    rr_arbiter #(.N(NUM_REQ)) u_arb (.req(req & ~grant_q), .ptr(ptr), .grant(sel));
    always_comb begin
        sel_id = '0;
        sel_op = '0;
        sel_ma = '0;
        sel_sz = '0;
        sel_oa = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (sel[i]) begin
                sel_id = 3'(i);
                sel_op = req_opcode[i];
                sel_ma = req_message_addr[i];
                sel_sz = req_size[i];
                sel_oa = req_output_addr[i];
            end
    end
`ifdef HASH_SCHED_TIMEOUT_EN
    logic [31:0] cnt;
    always_ff @(posedge clk or posedge reset)
        if (reset) cnt <= '0;
        else cnt <= (state == S_BUSY) ? cnt + 32'd1 : '0;
    assign timeout = state == S_BUSY && !hp_done && cnt == 32'(TIMEOUT_CYCLES - 1);
`else
    assign timeout = 1'b0;
`endif
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   state_nx = (|sel && sel_op != OP_ILLEGAL) ? S_ISSUE : S_IDLE;
            S_ISSUE:  state_nx = S_SETTLE;
            S_SETTLE: state_nx = S_BUSY;
            S_BUSY:   state_nx = hp_done ? S_COMPLETE : timeout ? S_IDLE : S_BUSY;
            default:  state_nx = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state           <= S_IDLE;
            ptr             <= '0;
            active_id       <= '0;
            grant_q         <= '0;
            err_q           <= '0;
            hp_opcode       <= '0;
            hp_message_addr <= '0;
            hp_size         <= '0;
            hp_output_addr  <= '0;
        end else begin
            state   <= state_nx;
            grant_q <= (state == S_IDLE) ? sel : '0;
            err_q   <= (state == S_IDLE && sel_op == OP_ILLEGAL) ? sel : '0;
            if (state == S_IDLE && |sel) begin
                ptr <= (sel_id == 3'(NUM_REQ - 1)) ? 3'd0 : sel_id + 3'd1;
                if (sel_op != OP_ILLEGAL) begin
                    active_id       <= sel_id;
                    hp_opcode       <= sel_op;
                    hp_message_addr <= sel_ma;
                    hp_size         <= sel_sz;
                    hp_output_addr  <= sel_oa;
                end
            end
        end
    always_comb begin
        req_done = '0;
        req_err  = err_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_done[i] = state == S_COMPLETE && active_id == 3'(i);
            if (timeout && active_id == 3'(i)) req_err[i] = 1'b1;
        end
    end
    assign req_grant = grant_q;
    assign hp_start  = state == S_ISSUE;
    assign busy      = state != S_IDLE;
endmodule

// File: tb/tb_hash_job_scheduler.sv
// tb_hash_job_scheduler: directed jobs against a scoreboard of expected grant/done/err events.
module tb_hash_job_scheduler;
    localparam int N = 4;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [N-1:0] req = '0;
    logic [N-1:0][1:0] req_opcode = '0;
    logic [N-1:0][31:0] req_message_addr = '0;
    logic [N-1:0][31:0] req_size = '0;
    logic [N-1:0][31:0] req_output_addr = '0;
    logic [N-1:0] req_grant, req_done, req_err;
    logic hp_start, busy;
    logic hp_done = 1'b0;
    logic [1:0] hp_opcode;
    logic [31:0] hp_message_addr, hp_size, hp_output_addr;
    logic [2:0] active_id;
    typedef struct {int kind; int id; logic [31:0] addr;} ev_t;
    ev_t sb[$];
    int checks = 0, errors = 0, starts = 0, exp_starts = 0, lat = 0;
    logic auto_drop = 1'b1;

    always #5 clk = ~clk;

    hash_job_scheduler #(.NUM_REQ(N), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .reset(reset), .req(req), .req_opcode(req_opcode),
        .req_message_addr(req_message_addr), .req_size(req_size), .req_output_addr(req_output_addr),
        .req_grant(req_grant), .req_done(req_done), .req_err(req_err),
        .hp_start(hp_start), .hp_opcode(hp_opcode), .hp_message_addr(hp_message_addr),
        .hp_size(hp_size), .hp_output_addr(hp_output_addr), .hp_done(hp_done),
        .busy(busy), .active_id(active_id)
    );

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(int kind, int id, logic [31:0] addr);
        ev_t e;
        e.kind = kind;
        e.id = id;
        e.addr = addr;
        sb.push_back(e);
    endtask

    task automatic drain(int budget);
        int n = 0;
        while ((sb.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_in_budget", n < budget, 1);
    endtask

    // hash processor: done level rises lat cycles after start, stale done cleared two cycles after start
    initial begin
        int left, clr;
        left = 0;
        clr = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                hp_done = 1'b0;
                left = 0;
                clr = 0;
            end else begin
                if (clr > 0) begin clr--; if (clr == 0) hp_done = 1'b0; end
                if (left > 0) begin left--; if (left == 0) hp_done = 1'b1; end
                if (hp_start) begin clr = 2; left = lat; end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (auto_drop) req = req & ~req_grant;
    end

    // monitor: pops one expected event per observed pulse bit
    initial begin
        logic hd_prev, st_prev;
        logic [N-1:0] v;
        ev_t e;
        hd_prev = 1'b0;
        st_prev = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (!reset) begin
                for (int k = 0; k < 3; k++)
                    for (int i = 0; i < N; i++) begin
                        v = (k == 0) ? req_grant : (k == 1) ? req_done : req_err;
                        if (v[i]) begin
                            if (sb.size() == 0) begin
                                checks++;
                                errors++;
                                $display("FAIL unexpected_event kind=%0d id=%0d required none", k, i);
                            end else begin
                                e = sb.pop_front();
                                chk("event_kind", k, e.kind);
                                chk("event_id", i, e.id);
                                if (k == 1) begin
                                    chk("done_addr", hp_message_addr, e.addr);
                                    chk("done_after_hp_done", {hd_prev, hp_done}, 2'b01);
                                end
                            end
                        end
                    end
                if (hp_start) begin
                    starts++;
                    chk("hp_start_single", st_prev, 0);
                    chk("busy_at_start", busy, 1);
                end
            end
            hd_prev = hp_done;
            st_prev = hp_start;
        end
    end

    initial begin
        int n, g, s0;
        // reset state, with a request pending that must not be granted
        req_opcode[0] = 2'b00;
        req_message_addr[0] = 32'h1000;
        req_size[0] = 32'd48;
        req_output_addr[0] = 32'h2000;
        req[0] = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_active_id", active_id, 0);
        chk("rst_hp_start", hp_start, 0);
        chk("rst_grant", req_grant, 0);
        chk("rst_done", req_done, 0);
        chk("rst_err", req_err, 0);
        chk("rst_hp_operands", {hp_opcode, hp_message_addr, hp_size[29:0]}, 0);
        chk("rst_hp_output_addr", hp_output_addr, 0);

        // single MD5 job, processor answers 400 cycles after start
        lat = 400;
        push(0, 0, 32'h0);
        push(1, 0, 32'h1000);
        exp_starts++;
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("job0_hp_size", hp_size, 48);
        chk("job0_busy", busy, 1);
        req_message_addr[0] = 32'hdead;
        drain(1000);

        // round robin with all four requesting continuously
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        auto_drop = 1'b0;
        lat = 7;
        for (int i = 0; i < N; i++) begin
            req_opcode[i] = 2'(i % 3);
            req_message_addr[i] = 32'h100 * (i + 1);
        end
        for (int j = 0; j < 6; j++) begin
            push(0, j % N, 32'h0);
            push(1, j % N, 32'h100 * ((j % N) + 1));
            exp_starts++;
        end
        req = 4'b1111;
        n = 0;
        g = 0;
        while (g < 6 && n < 2000) begin
            @(negedge clk);
            n++;
            if (|req_grant) g++;
        end
        req = '0;
        auto_drop = 1'b1;
        chk("rr_grant_count", g, 6);
        drain(200);

        // illegal opcode on 2, legal job queued on 3
        s0 = starts;
        req_opcode[2] = 2'b11;
        req_opcode[3] = 2'b10;
        req_message_addr[3] = 32'h3300;
        push(0, 2, 32'h0);
        push(2, 2, 32'h0);
        push(0, 3, 32'h0);
        push(1, 3, 32'h3300);
        exp_starts++;
        req = 4'b1100;
        drain(200);
        chk("illegal_no_extra_start", starts - s0, 1);

        // reset while BUSY on a job that never finishes
        lat = 0;
        req_opcode[1] = 2'b01;
        req_message_addr[1] = 32'h5500;
        push(0, 1, 32'h0);
        exp_starts++;
        req[1] = 1'b1;
        repeat (10) @(negedge clk);
        chk("mid_busy", busy, 1);
        chk("mid_active_id", active_id, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_busy", busy, 0);
        chk("async_active_id", active_id, 0);
        chk("async_hp_state", {hp_start, hp_opcode, hp_message_addr}, 0);
        chk("async_pulses", {req_grant, req_done, req_err}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset_sb_empty", sb.size(), 0);
        lat = 20;
        req_opcode[0] = 2'b10;
        req_message_addr[0] = 32'h6600;
        push(0, 0, 32'h0);
        push(1, 0, 32'h6600);
        exp_starts++;
        req[0] = 1'b1;
        drain(200);

`ifdef HASH_SCHED_TIMEOUT_EN
        lat = 0;
        req_opcode[3] = 2'b00;
        req_message_addr[3] = 32'h7700;
        push(0, 3, 32'h0);
        push(2, 3, 32'h0);
        exp_starts++;
        req[3] = 1'b1;
        n = 0;
        while (!req_grant[3] && n < 100) begin @(negedge clk); n++; end
        g = 1;
        n = 0;
        while (!req_err[3] && n < 400) begin
            @(negedge clk);
            n++;
            if (busy) g++;
        end
        chk("timeout_busy_cycles", g, 102);
        @(negedge clk);
        chk("timeout_busy_low", busy, 0);
        drain(50);
`endif

        chk("total_hp_starts", starts, exp_starts);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
